timer_core: RTL and testbench

//  Four-function stopwatch/timer counter that consumes the one-cycle tick from the clock divider (~0.01 s period).

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_core_bcd_digit.sv | 31 +++
 rtl/timer_core.sv | 136 +++++++++++++
 tb/tb_timer_core.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the stopwatch/timer counter: FSM states, count modes and BCD helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_UP0   = 2'b00;
  localparam logic [1:0] MODE_UPP   = 2'b01;
  localparam logic [1:0] MODE_DNMAX = 2'b10;
  localparam logic [1:0] MODE_DNP   = 2'b11;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Out-of-range preset nibbles saturate to nine.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_NINE) ? BCD_NINE : nib;
  endfunction

endpackage

// File: rtl/timer_core_bcd_digit.sv
// One BCD digit of the count chain: loadable, counts up or down, flags its wrap condition.
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] value,
  output logic       carry_out,
  output logic       borrow_out
);

  logic [3:0] inc_val;
  logic [3:0] dec_val;

  assign inc_val    = (value == BCD_NINE) ? 4'd0 : 4'(value + 4'd1);
  assign dec_val    = (value == 4'd0) ? BCD_NINE : 4'(value - 4'd1);
  // Wrap flags feed the enable of the next digit up the chain.
  assign carry_out  = (value == BCD_NINE);
  assign borrow_out = (value == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n)    value <= 4'd0;
    else if (load) value <= load_val;
    else if (en)   value <= dir ? dec_val : inc_val;
  end

endmodule

// File: rtl/timer_core.sv
// Stopwatch/timer counter over a chain of BCD digits with start/pause/clear control.
// Optional lap-hold display is enabled by defining TIMER_LAP_EN.
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned PRESET_DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       start_stop,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic [4*PRESET_DIGITS-1:0] preset,
`ifdef TIMER_LAP_EN
  input  logic                       lap,
`endif
  output logic [4*DIGITS-1:0]        digits,
  output logic                       running,
  output logic                       done
);

  localparam int unsigned W   = 4 * DIGITS;
  localparam int unsigned LOW = DIGITS - PRESET_DIGITS;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic              dir;
  logic              reload, ss_ev, tick_ev;
  logic              load, cnt_en, running_d, done_d;
  logic [W-1:0]      init_val;
  logic [W-1:0]      live;
  logic [DIGITS-1:0] en, carry, borrow;
  logic              at_term, pre_term;

  assign dir = mode_q[1];

  // Event decode in priority order: reload, start_stop, tick.
  assign reload  = clr | (mode != mode_q);
  assign ss_ev   = start_stop & ~reload;
  assign tick_ev = tick & ~reload & ~start_stop & (state_q == ST_RUN);

  // Initial value for the requested mode.
  always_comb begin
    init_val = '0;
    if (mode == MODE_DNMAX) begin
      for (int unsigned i = 0; i < DIGITS; i++) init_val[4*i +: 4] = BCD_NINE;
    end else if (mode == MODE_UPP || mode == MODE_DNP) begin
      for (int unsigned i = 0; i < PRESET_DIGITS; i++)
        init_val[4*(i+LOW) +: 4] = bcd_clamp(preset[4*i +: 4]);
    end
  end

  assign en[0] = cnt_en;
  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign en[i] = en[i-1] & (dir ? borrow[i-1] : carry[i-1]);
    end
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_val   (init_val[4*i +: 4]),
      .en         (en[i]),
      .dir        (dir),
      .value      (live[4*i +: 4]),
      .carry_out  (carry[i]),
      .borrow_out (borrow[i])
    );
  end

  // Terminal now, and terminal after one more count step.
  assign at_term  = dir ? (&borrow) : (&carry);
  assign pre_term = dir ? ((&borrow[DIGITS-1:1]) && (live[3:0] == 4'd1))
                        : ((&carry[DIGITS-1:1])  && (live[3:0] == 4'd8));

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= running_d;
      done    <= done_d;
      if (load) mode_q <= mode;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    if (reload) begin
      state_d = ST_IDLE;
    end else if (ss_ev) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = at_term ? ST_DONE : ST_RUN;
        ST_RUN:            state_d = ST_PAUSE;
        default:           state_d = state_q;
      endcase
    end else if (tick_ev && pre_term) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin : outputs
    load      = reload;
    cnt_en    = tick_ev;
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

`ifdef TIMER_LAP_EN
  logic         hold_q;
  logic [W-1:0] lap_q;

  // Lap toggles a frozen snapshot of the live count while counting continues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      lap_q  <= '0;
    end else if (reload || state_d == ST_DONE) begin
      hold_q <= 1'b0;
    end else if (lap && state_q == ST_RUN) begin
      hold_q <= ~hold_q;
      lap_q  <= live;
    end
  end

  assign digits = hold_q ? lap_q : live;
`else
  assign digits = live;
`endif

endmodule

// File: tb/tb_timer_core.sv
// Directed self-checking bench for timer_core (4 digits, 2 preset digits).
// Define TIMER_LAP_EN to also exercise the lap-hold feature.
module tb_timer_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        start_stop;
  logic        clr;
  logic [1:0]  mode;
  logic [7:0]  preset;
  logic [15:0] digits;
  logic        running;
  logic        done;
`ifdef TIMER_LAP_EN
  logic        lap;
`endif

  int checks = 0;
  int errors = 0;

  timer_core #(.DIGITS(4), .PRESET_DIGITS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start_stop (start_stop),
    .clr        (clr),
    .mode       (mode),
    .preset     (preset),
`ifdef TIMER_LAP_EN
    .lap        (lap),
`endif
    .digits     (digits),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp_d,
                     input logic exp_r, input logic exp_dn);
    checks++;
    assert (digits === exp_d && running === exp_r && done === exp_dn) else begin
      errors++;
      $error("FAIL %s: observed digits=%h running=%b done=%b, expected digits=%h running=%b done=%b",
             tag, digits, running, done, exp_d, exp_r, exp_dn);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_stop = 1'b0; clr = 1'b0;
    mode = 2'b00; preset = 8'h00;
`ifdef TIMER_LAP_EN
    lap = 1'b0;
`endif
    cyc(); cyc();
    rst_n = 1'b1;
    chk("reset", 16'h0000, 1'b0, 1'b0);

    // Up from zero, ripple carry and terminal at all nines
    pulse_ss();
    chk("start", 16'h0000, 1'b1, 1'b0);
    ticks(3);
    chk("up3", 16'h0003, 1'b1, 1'b0);
    ticks(6);
    chk("up9", 16'h0009, 1'b1, 1'b0);
    ticks(1);
    chk("carry10", 16'h0010, 1'b1, 1'b0);
    ticks(9988);
    chk("up9998", 16'h9998, 1'b1, 1'b0);
    ticks(1);
    chk("up_done", 16'h9999, 1'b0, 1'b1);
    ticks(1);
    chk("done_hold", 16'h9999, 1'b0, 1'b1);
    pulse_ss();
    chk("ss_in_done", 16'h9999, 1'b0, 1'b1);

    // Down from preset with borrow to zero
    mode = 2'b11; preset = 8'h01;
    cyc();
    chk("mode_dnp", 16'h0100, 1'b0, 1'b0);
    pulse_clr();
    chk("clr_dnp", 16'h0100, 1'b0, 1'b0);
    pulse_ss();
    ticks(1);
    chk("borrow99", 16'h0099, 1'b1, 1'b0);
    ticks(98);
    chk("dn0001", 16'h0001, 1'b1, 1'b0);
    ticks(1);
    chk("dn_done", 16'h0000, 1'b0, 1'b1);

    // Down from max, pause wins over same-cycle tick
    mode = 2'b10;
    cyc();
    chk("mode_dnmax", 16'h9999, 1'b0, 1'b0);
    pulse_ss();
    ticks(4999);
    chk("dn5000", 16'h5000, 1'b1, 1'b0);
    tick = 1'b1; start_stop = 1'b1;
    cyc();
    tick = 1'b0; start_stop = 1'b0;
    chk("pause_wins", 16'h5000, 1'b0, 1'b0);
    ticks(5);
    chk("pause_ticks", 16'h5000, 1'b0, 1'b0);
    pulse_ss();
    chk("resume", 16'h5000, 1'b1, 1'b0);
    ticks(1);
    chk("resume_cnt", 16'h4999, 1'b1, 1'b0);

    // Mode change mid-run with clamped preset, then clr beats start
    mode = 2'b00;
    cyc();
    chk("mode_up0", 16'h0000, 1'b0, 1'b0);
    pulse_ss();
    ticks(1234);
    chk("up1234", 16'h1234, 1'b1, 1'b0);
    mode = 2'b01; preset = 8'h7C;
    cyc();
    chk("clamp", 16'h7900, 1'b0, 1'b0);
    clr = 1'b1; start_stop = 1'b1;
    cyc();
    clr = 1'b0; start_stop = 1'b0;
    chk("clr_beats_ss", 16'h7900, 1'b0, 1'b0);

    // Start with the count already terminal goes straight to done
    mode = 2'b11; preset = 8'h00;
    cyc();
    chk("dnp_zero", 16'h0000, 1'b0, 1'b0);
    pulse_ss();
    chk("start_term", 16'h0000, 1'b0, 1'b1);

`ifdef TIMER_LAP_EN
    mode = 2'b00;
    cyc();
    pulse_ss();
    ticks(200);
    chk("lap_pre", 16'h0200, 1'b1, 1'b0);
    lap = 1'b1; cyc(); lap = 1'b0;
    ticks(10);
    chk("lap_hold", 16'h0200, 1'b1, 1'b0);
    lap = 1'b1; cyc(); lap = 1'b0;
    chk("lap_release", 16'h0210, 1'b1, 1'b0);
`endif

    // Reset in the middle of a run
    mode = 2'b00;
    cyc();
    pulse_ss();
    ticks(7);
    chk("pre_rst", 16'h0007, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst", 16'h0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
